multi_timer: RTL and testbench
==============================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (legal 1..8).
REQ-002 SHALL have parameter CNT_W, default 16, counter/reload width in bits (legal 9..16).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  chip select, qualifies every bus access.
REQ-006 SHALL have port we_n  input  1  high = read, low = write.
REQ-007 SHALL have port A  input  6  address: A[5:3] = channel index, A[2:0] = register offset.
REQ-008 SHALL have port DI  input  8  write data from processor.
REQ-009 SHALL have port DO  output  8  registered read data to processor.
REQ-010 SHALL have port OE  output  1  high while DO carries valid read data.
REQ-011 SHALL have port irq_n  output  1  combined interrupt, active-low, registered.

Function
REQ-012 SHALL decode register offsets per channel: 0 CTRL (R/W), 1 RELOAD_LO (W), 2 RELOAD_HI (W), 3 COUNT_LO (R), 4 COUNT_HI_SNAP (R), 5 STATUS (R, clear-on-read), 6 FLAGS_ALL (R, global, channel field ignored); offset 7 and channel index >= NUM_CH SHALL be ignored on write and return 0x00 with OE=1 on read.
REQ-013 CTRL SHALL be bits[1:0] prescale select (00 /1, 01 /8, 10 /64, 11 /1024), bit2 irq_en, bit3 mode (0 one-shot, 1 continuous), bit4 run; bits[7:5] read 0.
REQ-014 RELOAD_HI write SHALL stage DI[CNT_W-9:0] only; RELOAD_LO write SHALL commit {staged_hi, DI} to reload, load count = that value, clear prescaler, clear flag, set run=1.
REQ-015 Per-channel prescaler SHALL count 0..div-1 while run=1 and emit one tick in the cycle it equals div-1 (every cycle for /1), then wrap to 0.
REQ-016 On tick with count != 0: count SHALL decrement by 1.
REQ-017 On tick with count == 0: flag SHALL set; continuous mode SHALL reload count from reload; one-shot mode SHALL hold count at 0 and clear run.
REQ-018 A CTRL write SHALL not alter count or prescaler except that a prescale-select change SHALL clear the prescaler.
REQ-019 A bus write to a channel SHALL take priority over a tick in the same cycle for that channel.
REQ-020 Reads (enable=1, we_n=1) SHALL present DO and OE=1 exactly one cycle later; otherwise next cycle DO=0x00, OE=0.
REQ-021 COUNT_LO read SHALL return count[7:0] and latch count[CNT_W-1:8] into the snapshot; COUNT_HI_SNAP read SHALL return the snapshot zero-extended.
REQ-022 STATUS read SHALL return {irq_en, 6'b0, flag} and clear flag; a flag set in the same cycle SHALL win (flag stays 1, read returns pre-set value).
REQ-023 FLAGS_ALL read SHALL return flag of channel i in bit i, unused bits 0, without clearing.
REQ-024 irq_n SHALL equal registered ~|(flag[i] & irq_en[i]) across all channels, one cycle after flag/irq_en change.
REQ-025 Count SHALL never wrap below 0 nor exceed 2^CNT_W-1; reload 0 in continuous mode SHALL set flag on every tick.

Reset
REQ-026 On rst=1 at a clock edge: all count, reload, staged_hi, snapshot, prescaler, flag, CTRL fields SHALL be 0 (run=0), DO=0x00, OE=0, irq_n=1.
REQ-027 Reset SHALL override any bus access or tick in the same cycle; reset mid-count SHALL abort the count with no flag set.

Structure
REQ-028 Package multi_timer_pkg SHALL hold register offset constants, CTRL bit positions, prescale-select encodings and divisor constants.
REQ-029 One sub-module timer_channel SHALL implement prescaler, counter, reload, flag and CTRL for one channel; multi_timer SHALL instantiate NUM_CH copies plus bus decode, read mux and irq combine.

Verification
REQ-030 Reset then write CH0 CTRL=0x04, RELOAD_HI=0x00, RELOAD_LO=0x03 at /1 -> flag set and irq_n=0 on 4th tick, one-shot, count holds 0.
REQ-031 CH1 CTRL=0x0D (/8? no: 0x0D = /8, irq_en, continuous), reload 2 -> flag every 24 clk, count sequence 2,1,0,2; STATUS read returns 0x81 then 0x80.
REQ-032 CH2 reload 0x1234 /1, read COUNT_LO then COUNT_HI_SNAP while running -> returned pair forms one consistent sample, HI=0x12 until low byte underflows.
REQ-033 STATUS read of CH0 in same cycle as its flag sets -> DO=0x80, flag remains 1, irq_n stays 0.
REQ-034 CH3 counting, assert rst for 1 cycle -> next cycle all outputs at reset values, FLAGS_ALL read returns 0x00, no irq.
REQ-035 Read offset 7 and channel 5 (NUM_CH=4) -> DO=0x00, OE=1 one cycle later; writes there change no state.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: register map, CTRL layout and prescaler divisors for multi_timer
package multi_timer_pkg;
  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_RELOAD_LO = 3'd1;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd2;
  localparam logic [2:0] OFF_COUNT_LO  = 3'd3;
  localparam logic [2:0] OFF_COUNT_HI  = 3'd4;
  localparam logic [2:0] OFF_STATUS    = 3'd5;
  localparam logic [2:0] OFF_FLAGS_ALL = 3'd6;
  localparam int CTRL_PSEL_LSB = 0;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_MODE     = 3;
  localparam int CTRL_RUN      = 4;
  localparam logic [1:0] PSEL_DIV1    = 2'd0;
  localparam logic [1:0] PSEL_DIV8    = 2'd1;
  localparam logic [1:0] PSEL_DIV64   = 2'd2;
  localparam logic [1:0] PSEL_DIV1024 = 2'd3;
  localparam int PRESC_W = 10;
  localparam logic [PRESC_W-1:0] DIV1_M1    = 10'd0;
  localparam logic [PRESC_W-1:0] DIV8_M1    = 10'd7;
  localparam logic [PRESC_W-1:0] DIV64_M1   = 10'd63;
  localparam logic [PRESC_W-1:0] DIV1024_M1 = 10'd1023;
  function automatic logic [PRESC_W-1:0] div_m1(input logic [1:0] psel);
    return psel == PSEL_DIV1 ? DIV1_M1 : psel == PSEL_DIV8 ? DIV8_M1 :
           psel == PSEL_DIV64 ? DIV64_M1 : DIV1024_M1;
  endfunction
endpackage

// File: rtl/multi_timer_channel.sv
// timer_channel: one prescaled down-counter with reload, flag and CTRL register
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ctrl,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic             rd_lo,
  input  logic             rd_status,
  input  logic [7:0]       din,
  output logic [7:0]       count_lo,
  output logic [CNT_W-9:0] snap,
  output logic             flag,
  output logic             irq_en,
  output logic [7:0]       ctrl
);
  logic [CNT_W-1:0]   count_q, count_d, reload_q, reload_d;
  logic [CNT_W-9:0]   hi_q, hi_d, snap_q, snap_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         psel_q, psel_d;
  logic               flag_q, flag_d, irq_en_q, irq_en_d, mode_q, mode_d, run_q, run_d;
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    hi_d     = hi_q;
    presc_d  = presc_q;
    psel_d   = psel_q;
    irq_en_d = irq_en_q;
    mode_d   = mode_q;
    run_d    = run_q;
    flag_d   = flag_q & ~rd_status;
    snap_d   = rd_lo ? count_q[CNT_W-1:8] : snap_q;
    if (wr_ctrl) begin
      psel_d   = din[CTRL_PSEL_LSB +: 2];
      irq_en_d = din[CTRL_IRQ_EN];
      mode_d   = din[CTRL_MODE];
      run_d    = din[CTRL_RUN];
      presc_d  = psel_d != psel_q ? '0 : presc_q;
    end else if (wr_hi) begin
      hi_d = din[CNT_W-9:0];
    end else if (wr_lo) begin
      reload_d = {hi_q, din};
      count_d  = {hi_q, din};
      presc_d  = '0;
      flag_d   = 1'b0;
      run_d    = 1'b1;
    end else if (run_q) begin
      presc_d = presc_q == div_m1(psel_q) ? '0 : presc_q + 10'd1;
      if (presc_q == div_m1(psel_q)) begin
        count_d = count_q != '0 ? count_q - CNT_W'(1) : mode_q ? reload_q : '0;
        flag_d  = count_q == '0 ? 1'b1 : flag_d;
        run_d   = count_q != '0 || mode_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      reload_q <= '0;
      hi_q     <= '0;
      snap_q   <= '0;
      presc_q  <= '0;
      psel_q   <= '0;
      flag_q   <= 1'b0;
      irq_en_q <= 1'b0;
      mode_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      hi_q     <= hi_d;
      snap_q   <= snap_d;
      presc_q  <= presc_d;
      psel_q   <= psel_d;
      flag_q   <= flag_d;
      irq_en_q <= irq_en_d;
      mode_q   <= mode_d;
      run_q    <= run_d;
    end
  end
  assign count_lo = count_q[7:0];
  assign snap     = snap_q;
  assign flag     = flag_q;
  assign irq_en   = irq_en_q;
  assign ctrl     = {3'b000, run_q, mode_q, irq_en_q, psel_q};
endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH bus-mapped timer channels with registered read port and combined irq
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       we_n,
  input  logic [5:0] A,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       OE,
  output logic       irq_n
);
  logic [2:0]        ch, off;
  logic              wr, rd;
  logic [NUM_CH-1:0] sel, flags, irq_ens;
  logic [7:0]        ch_byte [NUM_CH];
  logic [7:0]        rd_byte, do_q, do_d;
  logic              oe_q, oe_d, irq_n_q, irq_n_d;
  assign ch  = A[5:3];
  assign off = A[2:0];
  assign wr  = enable & ~we_n;
  assign rd  = enable & we_n;
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    logic [7:0]       count_lo, ctrl;
    logic [CNT_W-9:0] snap;
    assign sel[i] = ch == 3'(i);
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_ctrl   (wr && sel[i] && off == OFF_CTRL),
      .wr_hi     (wr && sel[i] && off == OFF_RELOAD_HI),
      .wr_lo     (wr && sel[i] && off == OFF_RELOAD_LO),
      .rd_lo     (rd && sel[i] && off == OFF_COUNT_LO),
      .rd_status (rd && sel[i] && off == OFF_STATUS),
      .din       (DI),
      .count_lo  (count_lo),
      .snap      (snap),
      .flag      (flags[i]),
      .irq_en    (irq_ens[i]),
      .ctrl      (ctrl)
    );
    assign ch_byte[i] = off == OFF_CTRL     ? ctrl :
                        off == OFF_COUNT_LO ? count_lo :
                        off == OFF_COUNT_HI ? 8'(snap) :
                        off == OFF_STATUS   ? {irq_ens[i], 6'b000000, flags[i]} : 8'h00;
  end
  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NUM_CH; k++) rd_byte = rd_byte | (sel[k] ? ch_byte[k] : 8'h00);
    do_d    = !rd ? 8'h00 : off == OFF_FLAGS_ALL ? 8'(flags) : rd_byte;
    oe_d    = rd;
    irq_n_d = ~|(flags & irq_ens);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      do_q    <= 8'h00;
      oe_q    <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      do_q    <= do_d;
      oe_q    <= oe_d;
      irq_n_q <= irq_n_d;
    end
  end
  assign DO    = do_q;
  assign OE    = oe_q;
  assign irq_n = irq_n_q;
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed and random bus traffic scored against a behavioural timer model
module tb_multi_timer;
  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, we_n = 1'b1;
  logic [5:0] A = '0;
  logic [7:0] DI = '0;
  logic [7:0] DO;
  logic       OE, irq_n;
  multi_timer dut (
    .clk(clk), .rst(rst), .enable(enable), .we_n(we_n),
    .A(A), .DI(DI), .DO(DO), .OE(OE), .irq_n(irq_n)
  );
  always #5 clk = ~clk;
  int         vectors = 0, miscompares = 0;
  logic [7:0] exp_q[$];
  bit         exp_irq = 1'b1;
  bit         armed = 1'b0;
  int         m_cnt[4], m_rel[4], m_hi[4], m_snap[4], m_ph[4];
  bit         m_flag[4], m_ie[4], m_mode[4], m_run[4];
  bit [1:0]   m_psel[4];
  int         div_tab[4] = '{1, 8, 64, 1024};
  task automatic model(input bit r, input bit e, input bit w, input bit [5:0] a, input bit [7:0] d);
    int ch, off, clr;
    bit any;
    logic [7:0] b;
    any = 0;
    for (int c = 0; c < 4; c++) any |= m_flag[c] & m_ie[c];
    if (r) begin
      for (int c = 0; c < 4; c++) begin
        m_cnt[c] = 0; m_rel[c] = 0; m_hi[c] = 0; m_snap[c] = 0; m_ph[c] = 0;
        m_flag[c] = 0; m_ie[c] = 0; m_mode[c] = 0; m_run[c] = 0; m_psel[c] = 0;
      end
      exp_irq = 1'b1;
      return;
    end
    exp_irq = !any;
    ch = int'(a[5:3]);
    off = int'(a[2:0]);
    clr = -1;
    if (e && w) begin
      b = 8'h00;
      if (off == 6) begin
        for (int c = 0; c < 4; c++) b[c] = m_flag[c];
      end else if (ch < 4) begin
        if (off == 0) b = {3'b000, m_run[ch], m_mode[ch], m_ie[ch], m_psel[ch]};
        if (off == 3) begin
          b = 8'(m_cnt[ch] % 256);
          m_snap[ch] = m_cnt[ch] / 256;
        end
        if (off == 4) b = 8'(m_snap[ch]);
        if (off == 5) begin
          b = {m_ie[ch], 6'b000000, m_flag[ch]};
          clr = ch;
        end
      end
      exp_q.push_back(b);
    end
    for (int c = 0; c < 4; c++) begin
      if (c == clr) m_flag[c] = 0;
      if (e && !w && ch == c && off <= 2) begin
        if (off == 0) begin
          if (d[1:0] != m_psel[c]) m_ph[c] = 0;
          m_psel[c] = d[1:0]; m_ie[c] = d[2]; m_mode[c] = d[3]; m_run[c] = d[4];
        end else if (off == 2) begin
          m_hi[c] = int'(d);
        end else begin
          m_rel[c] = m_hi[c] * 256 + int'(d);
          m_cnt[c] = m_rel[c]; m_ph[c] = 0; m_flag[c] = 0; m_run[c] = 1;
        end
      end else if (m_run[c]) begin
        m_ph[c]++;
        if (m_ph[c] == div_tab[m_psel[c]]) begin
          m_ph[c] = 0;
          if (m_cnt[c] > 0) m_cnt[c]--;
          else begin
            m_flag[c] = 1;
            if (m_mode[c]) m_cnt[c] = m_rel[c];
            else m_run[c] = 0;
          end
        end
      end
    end
  endtask
  task automatic step(input bit r, input bit e, input bit w, input bit [5:0] a, input bit [7:0] d);
    @(negedge clk);
    #1;
    rst = r; enable = e; we_n = w; A = a; DI = d;
    model(r, e, w, a, d);
    armed = 1'b1;
  endtask
  task automatic wr(input bit [2:0] ch, input bit [2:0] off, input bit [7:0] d);
    step(0, 1, 0, {ch, off}, d);
  endtask
  task automatic rd(input bit [2:0] ch, input bit [2:0] off);
    step(0, 1, 1, {ch, off}, 8'($urandom));
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1'($urandom), 6'($urandom), 8'($urandom));
  endtask
  task automatic reset1();
    step(1, 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom));
  endtask
  always @(negedge clk) begin
    if (armed) begin
      logic [7:0] e;
      vectors++;
      if (irq_n !== exp_irq) begin
        miscompares++;
        $display("FAIL irq_n at %0t: got %b expected %b", $time, irq_n, exp_irq);
      end
      vectors++;
      if (OE === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_oe at %0t: got OE=1 DO=%h expected OE=0", $time, DO);
        end else begin
          e = exp_q.pop_front();
          if (DO !== e) begin
            miscompares++;
            $display("FAIL read_data at %0t: got %h expected %h", $time, DO, e);
          end
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        miscompares++;
        $display("FAIL missing_oe at %0t: got OE=%b DO=%h expected OE=1 DO=%h", $time, OE, DO, e);
      end else if (DO !== 8'h00 || OE !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_bus at %0t: got OE=%b DO=%h expected OE=0 DO=00", $time, OE, DO);
      end
    end
  end
  initial begin
    reset1();
    idle(2);
    wr(0, 0, 8'h04); wr(0, 2, 8'h00); wr(0, 1, 8'h03);
    idle(6);
    rd(0, 3); rd(0, 0); rd(0, 5); rd(0, 5);
    reset1();
    wr(0, 0, 8'h04); wr(0, 2, 8'h00); wr(0, 1, 8'h03);
    idle(3);
    rd(0, 5); idle(2); rd(0, 5); rd(0, 6);
    reset1();
    wr(1, 0, 8'h0D); wr(1, 2, 8'h00); wr(1, 1, 8'h02);
    for (int k = 0; k < 30; k++) begin
      rd(1, 3);
      idle(2);
    end
    rd(1, 5); rd(1, 5); idle(20); rd(1, 5); rd(1, 6);
    wr(2, 0, 8'h00); wr(2, 2, 8'h12); wr(2, 1, 8'h34);
    for (int k = 0; k < 40; k++) begin
      rd(2, 3); rd(2, 4);
      idle($urandom_range(0, 2));
    end
    wr(3, 0, 8'h05); wr(3, 2, 8'h00); wr(3, 1, 8'h10);
    idle(20);
    rd(3, 3);
    reset1();
    rd(7, 6); rd(3, 3); rd(3, 0);
    wr(0, 0, 8'h04); wr(0, 1, 8'h05);
    rd(0, 7); rd(5, 0); rd(5, 5); rd(7, 7);
    wr(5, 1, 8'h00); wr(5, 0, 8'h1F); wr(0, 7, 8'hFF); wr(0, 3, 8'hAA);
    rd(0, 0); rd(0, 3); rd(2, 6);
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit [2:0] c, o;
      bit [7:0] d;
      r = int'($urandom_range(0, 199));
      c = 3'($urandom_range(0, 4));
      o = r < 190 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      d = 8'($urandom);
      if (o == 0) d[1] = ($urandom_range(0, 7) == 0);
      if (o == 2) d = 8'($urandom_range(0, 1));
      if (o == 1) d = 8'($urandom_range(0, 12));
      if (r == 0) reset1();
      else if (r < 110) idle(1);
      else if (r < 150) rd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      else wr(c, o, d);
    end
    idle(3);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
